proc_seq_ctrl: RTL and testbench
================================

# proc_seq_ctrl

Parametrised multicycle sequencer for the ARM-subset processor: owns the program counter, instruction register, NZCV flag register and the control state machine. Replaces the free-running fetch-every-cycle arrangement with a handshake-based FETCH/DECODE/EXECUTE/WRITEBACK sequence, conditional execution and wait-state tolerant instruction and data memory access. It sits between instruction memory, the instruction decoder, register file, ALU and data memory in the processor top.

## Interface
- ADDR_W, 9, width of program counter / instruction address
- PC_STEP, 4, PC increment per retired or skipped instruction
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run enable; low holds the sequencer in IDLE at an instruction boundary
- instr_addr  out  ADDR_W  current PC
- instr_req  out  1  instruction fetch request
- instr_ready  in  1  instruction memory has valid `instr` this cycle
- instr  in  32  instruction word from memory
- ir  out  32  latched instruction register
- alu_flags  in  4  NZCV from the ALU (bit3 N, bit2 Z, bit1 C, bit0 V)
- flags  out  4  registered NZCV
- branch_target  in  ADDR_W  branch address computed by the datapath
- alu_src_imm  out  1  ALU B operand = immediate (ir[25] for data-processing, 1 for load/store)
- alu_op  out  4  ALU opcode (ir[24:21] for data-processing, 4'b0100 ADD for load/store)
- mem_req  out  1  data memory request
- mem_we  out  1  data memory write (store)
- mem_ready  in  1  data memory done / read data valid
- wb_sel  out  1  register write-back source: 0 ALU result, 1 memory data
- reg_we  out  1  register file write enable
- instr_count  out  CNT_W  retired instructions (condition passed)
- fault  out  1  undefined instruction trapped

## Operation
- Op = ir[27:26]: 00 data-processing, 01 load/store (L = ir[20]), 10 branch, 11 undefined.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, FAULT.
- IDLE: start=1 -> FETCH.
- FETCH: instr_req=1, instr_addr stable. On instr_ready=1: ir <= instr -> DECODE. Otherwise stay.
- DECODE: evaluate ir[31:28] against flags (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 = never).
  - Fail: PC <= PC+PC_STEP -> FETCH (IDLE if start=0).
  - Pass: Op 00 -> EXEC; 01 -> MEM; 10 -> BRANCH; 11 -> FAULT.
- EXEC: alu_src_imm/alu_op driven. If S=ir[20]=1 or opcode 1000-1011 (TST,TEQ,CMP,CMN): flags <= alu_flags. Compare ops -> retire; others -> WB with wb_sel=0.
- MEM: mem_req=1, mem_we=!L, alu_op=ADD, alu_src_imm=1. Held until mem_ready=1; then load -> WB (wb_sel=1), store -> retire.
- WB: reg_we=1 for exactly one cycle -> retire.
- BRANCH: PC <= branch_target, instr_count++ -> FETCH/IDLE. No PC_STEP added.
- Retire: PC <= PC+PC_STEP, instr_count++ -> FETCH if start=1 else IDLE.
- FAULT: fault=1, all requests/enables low, PC frozen; exits only on reset.
- PC and instr_count wrap modulo 2^ADDR_W / 2^CNT_W.
- start=0 mid-instruction: current instruction completes, then IDLE.
- Control outputs (reg_we, mem_req, mem_we, instr_req) are 0 in every state not listed for them.

## Timing
- Reset (rst=0, async): state IDLE, instr_addr=0, ir=0, flags=0, instr_count=0, fault=0, all request/enable outputs 0, wb_sel=0, alu_src_imm=0, alu_op=0. Release synchronous to clk.
- Minimum cycles per instruction with zero wait states: cond-fail 2; branch, compare, store 3; data-processing write and load 4.
- Each wait cycle with instr_ready=0 or mem_ready=0 adds one cycle; request stays high, address/ir stable.
- instr_ready/mem_ready sampled only while the matching request is high; ignored otherwise.
- flags update visible the cycle after EXEC; next instruction's DECODE sees it.
- PC/instr_count update on the edge leaving the retiring state.
- Moore outputs registered from state; no combinational path from instr_ready/mem_ready to any output.

## Test plan
- Reset: rst=0 during FETCH with instr_req high -> all outputs zero immediately, IDLE; start=1 after release -> instr_req=1, instr_addr=0.
- ADD R1,R2,#5 (0xE2821005), instr_ready=1 first cycle -> reg_we high exactly on 4th cycle, wb_sel=0, instr_addr 0->4, instr_count=1.
- CMP then BEQ: alu_flags=4'b0100 during CMP EXEC -> flags=0100; BEQ (0x0A000002) with branch_target=0x40 -> instr_addr=0x40 after 3 cycles, no reg_we.
- Cond fail: flags Z=0, instruction 0x03A01001 (MOVEQ) -> 2 cycles, PC+4, instr_count unchanged, no reg_we.
- LDR with mem_ready held low 3 cycles -> mem_req high 4 cycles, mem_we=0, then reg_we with wb_sel=1; STR same wait -> mem_we=1, no reg_we.
- Undefined op ir[27:26]=11 -> fault=1, PC frozen, instr_req low indefinitely; PC wrap at ADDR_W=9 from 0x1FC -> 0x000.

Source files
------------

// File: rtl/proc_seq_ctrl.sv
// Multicycle sequencer for the ARM-subset processor.
// Owns PC, instruction register, NZCV flags and the control FSM. Walks every instruction
// through FETCH/DECODE and then EXEC, MEM, WB or BRANCH, with handshaked instruction
// and data memory. All control outputs are decoded from the registered state only.
module proc_seq_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_req,
  input  logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [31:0]       ir,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              alu_src_imm,
  output logic [3:0]        alu_op,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              wb_sel,
  output logic              reg_we,
  output logic [CNT_W-1:0]  instr_count,
  output logic              fault
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StBranch,
    StFault
  } state_e;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpLdSt   = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [3:0] AluAdd   = 4'b0100;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [3:0]          flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Instruction fields of the latched word.
  logic [3:0] cond_field;
  logic [1:0] op_field;
  logic [3:0] opcode_field;
  logic       s_bit;
  logic       imm_bit;
  logic       is_compare;
  logic       is_load;
  logic       cond_ok;

  // ARM condition evaluation against the registered NZCV.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_field   = ir_q[31:28];
  assign op_field     = ir_q[27:26];
  assign imm_bit      = ir_q[25];
  assign opcode_field = ir_q[24:21];
  assign s_bit        = ir_q[20];
  assign is_load      = ir_q[20];
  // TST/TEQ/CMP/CMN: opcodes 10xx set flags and never write a register.
  assign is_compare   = (opcode_field[3:2] == 2'b10);
  assign cond_ok      = cond_pass(cond_field, flags_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Architectural registers: PC, IR, flags and retired count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and register update logic; retiring returns to FETCH only while start is high.
  always_comb begin
    state_e after_instr;
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    after_instr = start ? StFetch : StIdle;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (instr_ready) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (!cond_ok) begin
          // Skipped instruction: advance PC but do not count it as retired.
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = after_instr;
        end else begin
          case (op_field)
            OpDp:     state_d = StExec;
            OpLdSt:   state_d = StMem;
            OpBranch: state_d = StBranch;
            default:  state_d = StFault;
          endcase
        end
      end

      StExec: begin
        if (s_bit || is_compare) begin
          flags_d = alu_flags;
        end
        if (is_compare) begin
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = after_instr;
        end else begin
          state_d = StWb;
        end
      end

      StMem: begin
        if (mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pc_d    = pc_q + ADDR_W'(PC_STEP);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = after_instr;
          end
        end
      end

      StWb: begin
        pc_d    = pc_q + ADDR_W'(PC_STEP);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = after_instr;
      end

      StBranch: begin
        pc_d    = branch_target;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = after_instr;
      end

      StFault: begin
        // Trapped until reset.
        state_d = StFault;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore control outputs decoded from the current state and latched IR.
  always_comb begin
    instr_req   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 4'b0000;
    fault       = 1'b0;

    case (state_q)
      StFetch: begin
        instr_req = 1'b1;
      end
      StExec: begin
        alu_src_imm = imm_bit;
        alu_op      = opcode_field;
      end
      StMem: begin
        mem_req     = 1'b1;
        mem_we      = !is_load;
        alu_src_imm = 1'b1;
        alu_op      = AluAdd;
      end
      StWb: begin
        reg_we = 1'b1;
        wb_sel = (op_field == OpLdSt);
      end
      StFault: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign instr_addr  = pc_q;
  assign ir          = ir_q;
  assign flags       = flags_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Self-checking bench for proc_seq_ctrl: per-instruction expectations are queued when an
// instruction is issued and popped when the sequencer returns to the next fetch.
module tb_proc_seq_ctrl;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 16;

  localparam logic [31:0] InsAdd   = 32'hE2821005;  // ADD R1,R2,#5
  localparam logic [31:0] InsCmp   = 32'hE3510000;  // CMP R1,#0
  localparam logic [31:0] InsBeq   = 32'h0A000002;  // BEQ
  localparam logic [31:0] InsBal   = 32'hEA000000;  // B
  localparam logic [31:0] InsMoveq = 32'h03A01001;  // MOVEQ R1,#1
  localparam logic [31:0] InsLdr   = 32'hE5912000;  // LDR R2,[R1]
  localparam logic [31:0] InsStr   = 32'hE5812000;  // STR R2,[R1]
  localparam logic [31:0] InsUndef = 32'hEC000000;  // op field 11

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_req;
  logic              instr_ready = 1'b0;
  logic [31:0]       instr = '0;
  logic [31:0]       ir;
  logic [3:0]        alu_flags = '0;
  logic [3:0]        flags;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              alu_src_imm;
  logic [3:0]        alu_op;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic              wb_sel;
  logic              reg_we;
  logic [CNT_W-1:0]  instr_count;
  logic              fault;

  proc_seq_ctrl #(
    .ADDR_W (ADDR_W),
    .PC_STEP(4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .ir           (ir),
    .alu_flags    (alu_flags),
    .flags        (flags),
    .branch_target(branch_target),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .wb_sel       (wb_sel),
    .reg_we       (reg_we),
    .instr_count  (instr_count),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          we_cnt;
    int          we_cyc;
    logic        wbsel;
    int          mreq;
    logic        mwe;
    logic [31:0] ir;
    logic [3:0]  op1;
    logic        imm1;
    logic        addr_moved;
  } rec_t;

  rec_t sbq[$];

  int checks = 0;
  int passes = 0;

  logic [ADDR_W-1:0] m_pc;
  logic [CNT_W-1:0]  m_cnt;
  logic [3:0]        m_flags;

  // Reference condition evaluation, grouped by condition pair.
  function automatic logic tb_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = ~r;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from FETCH until the next FETCH, serving both handshakes.
  task automatic exec_instr(input logic [31:0] iw, input int iwait, input int mwait,
                            input logic [3:0] af, input logic [ADDR_W-1:0] tgt,
                            output rec_t o);
    int   iw_left = iwait;
    int   mw_left = mwait;
    int   leave_cyc = 0;
    logic left = 1'b0;
    logic [ADDR_W-1:0] a0 = instr_addr;
    o = '{default: 0};
    o.cycles = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (instr_req && left) begin
        o.cycles = cyc - 1;
        break;
      end
      if (instr_req && instr_addr !== a0) o.addr_moved = 1'b1;
      if (!instr_req && !left) begin
        left = 1'b1;
        leave_cyc = cyc;
        o.ir = ir;
      end
      if (left && cyc == leave_cyc + 1) begin
        o.op1 = alu_op;
        o.imm1 = alu_src_imm;
      end
      if (reg_we) begin
        o.we_cnt++;
        o.we_cyc = cyc;
        o.wbsel = wb_sel;
      end
      if (mem_req) begin
        o.mreq++;
        o.mwe |= mem_we;
      end
      instr = iw;
      alu_flags = af;
      branch_target = tgt;
      instr_ready = instr_req && (iw_left == 0);
      if (instr_req && iw_left > 0) iw_left--;
      mem_ready = mem_req && (mw_left == 0);
      if (mem_req && mw_left > 0) mw_left--;
      step();
    end
    instr_ready = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    step();
    step();
    checks++;
    if ({instr_addr, instr_req, ir, flags, alu_src_imm, alu_op, mem_req, mem_we, wb_sel,
         reg_we, instr_count, fault} !== '0)
      $display("FAIL reset_outputs: got addr=%h req=%b ir=%h flags=%h cnt=%h fault=%b want 0",
               instr_addr, instr_req, ir, flags, instr_count, fault);
    else passes++;
    rst = 1'b1;
    step();
    checks++;
    if (instr_req !== 1'b0) $display("FAIL idle_hold: instr_req=%b want 0", instr_req);
    else passes++;
    start = 1'b1;
    step();
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== 9'h000)
      $display("FAIL first_fetch: req=%b addr=%h want 1/000", instr_req, instr_addr);
    else passes++;
    m_pc = '0;
    m_cnt = '0;
    m_flags = '0;
  endtask

  task automatic test_add();
    rec_t e, o;
    for (int w = 0; w <= 2; w += 2) begin
      e = '{default: 0};
      e.cycles = 4 + w; e.we_cnt = 1; e.we_cyc = 4 + w; e.wbsel = 1'b0;
      e.ir = InsAdd; e.op1 = 4'b0100; e.imm1 = 1'b1;
      sbq.push_back(e);
      exec_instr(InsAdd, w, 0, 4'b1111, 9'h000, o);
      e = sbq.pop_front();
      m_pc += 9'd4;
      m_cnt++;
      checks++;
      if (o.cycles !== e.cycles) $display("FAIL add_cycles: got %0d want %0d", o.cycles, e.cycles);
      else passes++;
      checks++;
      if (o.we_cnt !== e.we_cnt || o.we_cyc !== e.we_cyc || o.wbsel !== e.wbsel)
        $display("FAIL add_wb: we_cnt=%0d cyc=%0d sel=%b want %0d/%0d/%b",
                 o.we_cnt, o.we_cyc, o.wbsel, e.we_cnt, e.we_cyc, e.wbsel);
      else passes++;
      checks++;
      if (o.ir !== e.ir || o.op1 !== e.op1 || o.imm1 !== e.imm1 || o.addr_moved)
        $display("FAIL add_decode: ir=%h op=%h imm=%b moved=%b want %h/%h/%b/0",
                 o.ir, o.op1, o.imm1, o.addr_moved, e.ir, e.op1, e.imm1);
      else passes++;
      checks++;
      if (instr_addr !== m_pc || instr_count !== m_cnt || flags !== m_flags)
        $display("FAIL add_state: pc=%h cnt=%0d flags=%h want %h/%0d/%h",
                 instr_addr, instr_count, flags, m_pc, m_cnt, m_flags);
      else passes++;
    end
  endtask

  task automatic test_cmp_beq();
    rec_t e, o;
    e = '{default: 0};
    e.cycles = 3; e.op1 = 4'b1010; e.imm1 = 1'b1;
    sbq.push_back(e);
    exec_instr(InsCmp, 0, 0, 4'b0100, 9'h000, o);
    e = sbq.pop_front();
    m_pc += 9'd4; m_cnt++; m_flags = 4'b0100;
    checks++;
    if (o.cycles !== e.cycles || o.we_cnt !== 0 || o.op1 !== e.op1 || o.imm1 !== e.imm1)
      $display("FAIL cmp_exec: cyc=%0d we=%0d op=%h imm=%b want %0d/0/%h/%b",
               o.cycles, o.we_cnt, o.op1, o.imm1, e.cycles, e.op1, e.imm1);
    else passes++;
    checks++;
    if (flags !== m_flags || instr_addr !== m_pc || instr_count !== m_cnt)
      $display("FAIL cmp_state: flags=%h pc=%h cnt=%0d want %h/%h/%0d",
               flags, instr_addr, instr_count, m_flags, m_pc, m_cnt);
    else passes++;
    e = '{default: 0};
    e.cycles = 3;
    sbq.push_back(e);
    exec_instr(InsBeq, 0, 0, 4'b1011, 9'h040, o);
    e = sbq.pop_front();
    m_pc = 9'h040; m_cnt++;
    checks++;
    if (o.cycles !== e.cycles || o.we_cnt !== 0 || o.mreq !== 0)
      $display("FAIL beq_cycles: cyc=%0d we=%0d mreq=%0d want %0d/0/0",
               o.cycles, o.we_cnt, o.mreq, e.cycles);
    else passes++;
    checks++;
    if (instr_addr !== m_pc || instr_count !== m_cnt || flags !== m_flags)
      $display("FAIL beq_state: pc=%h cnt=%0d flags=%h want %h/%0d/%h",
               instr_addr, instr_count, flags, m_pc, m_cnt, m_flags);
    else passes++;
  endtask

  task automatic test_cond_fail();
    rec_t e, o;
    exec_instr(InsCmp, 0, 0, 4'b0000, 9'h000, o);
    m_pc += 9'd4; m_cnt++; m_flags = 4'b0000;
    e = '{default: 0};
    e.cycles = 2;
    sbq.push_back(e);
    exec_instr(InsMoveq, 0, 0, 4'b1111, 9'h000, o);
    e = sbq.pop_front();
    m_pc += 9'd4;
    checks++;
    if (o.cycles !== e.cycles || o.we_cnt !== 0)
      $display("FAIL condfail_cycles: cyc=%0d we=%0d want %0d/0", o.cycles, o.we_cnt, e.cycles);
    else passes++;
    checks++;
    if (instr_addr !== m_pc || instr_count !== m_cnt || flags !== m_flags)
      $display("FAIL condfail_state: pc=%h cnt=%0d flags=%h want %h/%0d/%h",
               instr_addr, instr_count, flags, m_pc, m_cnt, m_flags);
    else passes++;
  endtask

  task automatic test_ldr_str();
    rec_t e, o;
    // Load: one fetch wait, three data wait cycles.
    e = '{default: 0};
    e.cycles = 8; e.we_cnt = 1; e.we_cyc = 8; e.wbsel = 1'b1; e.mreq = 4; e.mwe = 1'b0;
    e.op1 = 4'b0100; e.imm1 = 1'b1;
    sbq.push_back(e);
    exec_instr(InsLdr, 1, 3, 4'b1111, 9'h000, o);
    e = sbq.pop_front();
    m_pc += 9'd4; m_cnt++;
    checks++;
    if (o.cycles !== e.cycles || o.mreq !== e.mreq || o.mwe !== e.mwe)
      $display("FAIL ldr_mem: cyc=%0d mreq=%0d mwe=%b want %0d/%0d/%b",
               o.cycles, o.mreq, o.mwe, e.cycles, e.mreq, e.mwe);
    else passes++;
    checks++;
    if (o.we_cnt !== e.we_cnt || o.we_cyc !== e.we_cyc || o.wbsel !== e.wbsel)
      $display("FAIL ldr_wb: we=%0d cyc=%0d sel=%b want %0d/%0d/%b",
               o.we_cnt, o.we_cyc, o.wbsel, e.we_cnt, e.we_cyc, e.wbsel);
    else passes++;
    checks++;
    if (o.op1 !== e.op1 || o.imm1 !== e.imm1 || o.addr_moved)
      $display("FAIL ldr_alu: op=%h imm=%b moved=%b want %h/%b/0",
               o.op1, o.imm1, o.addr_moved, e.op1, e.imm1);
    else passes++;
    e = '{default: 0};
    e.cycles = 6; e.mreq = 4; e.mwe = 1'b1;
    sbq.push_back(e);
    exec_instr(InsStr, 0, 3, 4'b1111, 9'h000, o);
    e = sbq.pop_front();
    m_pc += 9'd4; m_cnt++;
    checks++;
    if (o.cycles !== e.cycles || o.mreq !== e.mreq || o.mwe !== e.mwe || o.we_cnt !== 0)
      $display("FAIL str_mem: cyc=%0d mreq=%0d mwe=%b we=%0d want %0d/%0d/%b/0",
               o.cycles, o.mreq, o.mwe, o.we_cnt, e.cycles, e.mreq, e.mwe);
    else passes++;
    checks++;
    if (instr_addr !== m_pc || instr_count !== m_cnt)
      $display("FAIL ldst_state: pc=%h cnt=%0d want %h/%0d", instr_addr, instr_count, m_pc, m_cnt);
    else passes++;
  endtask

  task automatic test_cond_codes();
    rec_t e, o;
    logic [3:0]  f;
    logic [3:0]  c;
    logic        p;
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      c = 4'(i % 16);
      f = 4'($urandom_range(0, 15));
      exec_instr(InsCmp, 0, 0, f, 9'h000, o);
      m_pc += 9'd4; m_cnt++; m_flags = f;
      p = tb_cond(c, f);
      w = {c, 28'h3A01001};
      e = '{default: 0};
      e.cycles = p ? 4 : 2;
      e.we_cnt = p ? 1 : 0;
      sbq.push_back(e);
      exec_instr(w, 0, 0, 4'b0000, 9'h000, o);
      e = sbq.pop_front();
      m_pc += 9'd4;
      if (p) m_cnt++;
      checks++;
      if (o.cycles !== e.cycles || o.we_cnt !== e.we_cnt)
        $display("FAIL cond_%h_flags_%h: cyc=%0d we=%0d want %0d/%0d",
                 c, f, o.cycles, o.we_cnt, e.cycles, e.we_cnt);
      else passes++;
    end
    checks++;
    if (instr_addr !== m_pc || instr_count !== m_cnt || flags !== m_flags)
      $display("FAIL cond_state: pc=%h cnt=%0d flags=%h want %h/%0d/%h",
               instr_addr, instr_count, flags, m_pc, m_cnt, m_flags);
    else passes++;
  endtask

  task automatic test_start_low();
    instr = InsAdd;
    instr_ready = 1'b1;
    start = 1'b0;
    step();
    instr_ready = 1'b0;
    step();
    step();
    checks++;
    if (reg_we !== 1'b1) $display("FAIL startlow_wb: reg_we=%b want 1", reg_we);
    else passes++;
    step();
    m_pc += 9'd4; m_cnt++;
    repeat (3) step();
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== m_pc || instr_count !== m_cnt)
      $display("FAIL startlow_idle: req=%b pc=%h cnt=%0d want 0/%h/%0d",
               instr_req, instr_addr, instr_count, m_pc, m_cnt);
    else passes++;
    start = 1'b1;
    step();
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== m_pc)
      $display("FAIL startlow_resume: req=%b pc=%h want 1/%h", instr_req, instr_addr, m_pc);
    else passes++;
  endtask

  task automatic test_pc_wrap();
    rec_t o;
    exec_instr(InsBal, 0, 0, 4'b0000, 9'h1FC, o);
    m_pc = 9'h1FC; m_cnt++;
    checks++;
    if (instr_addr !== m_pc) $display("FAIL wrap_branch: pc=%h want %h", instr_addr, m_pc);
    else passes++;
    exec_instr(InsAdd, 0, 0, 4'b0000, 9'h000, o);
    m_pc += 9'd4; m_cnt++;
    checks++;
    if (instr_addr !== 9'h000 || instr_addr !== m_pc || instr_count !== m_cnt)
      $display("FAIL wrap_pc: pc=%h cnt=%0d want 000/%0d", instr_addr, instr_count, m_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid();
    rec_t o;
    exec_instr(InsCmp, 0, 0, 4'b1010, 9'h000, o);
    exec_instr(InsAdd, 0, 0, 4'b0000, 9'h000, o);
    instr_ready = 1'b0;
    step();
    checks++;
    if (instr_req !== 1'b1 || instr_addr === 9'h000 || flags !== 4'b1010)
      $display("FAIL resetmid_pre: req=%b pc=%h flags=%h want 1/nonzero/a",
               instr_req, instr_addr, flags);
    else passes++;
    #2;
    rst = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if ({instr_addr, instr_req, ir, flags, instr_count, fault, reg_we, mem_req} !== '0)
      $display("FAIL resetmid_async: addr=%h req=%b ir=%h flags=%h cnt=%0d want 0",
               instr_addr, instr_req, ir, flags, instr_count);
    else passes++;
    step();
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== 9'h000)
      $display("FAIL resetmid_restart: req=%b addr=%h want 1/000", instr_req, instr_addr);
    else passes++;
    m_pc = '0; m_cnt = '0; m_flags = '0;
  endtask

  task automatic test_fault();
    int bad = 0;
    instr = InsUndef;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1) $display("FAIL fault_entry: fault=%b want 1", fault);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      step();
      if (fault !== 1'b1 || instr_req !== 1'b0 || reg_we !== 1'b0 || mem_req !== 1'b0 ||
          mem_we !== 1'b0 || instr_addr !== m_pc || instr_count !== m_cnt) bad++;
    end
    instr_ready = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (bad !== 0) $display("FAIL fault_hold: %0d bad cycles, want 0", bad);
    else passes++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) $display("FAIL fault_clear: fault=%b want 0", fault);
    else passes++;
    step();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_beq();
    test_cond_fail();
    test_ldr_str();
    test_cond_codes();
    test_start_low();
    test_pc_wrap();
    test_reset_mid();
    test_fault();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
